// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_e;

   localparam int unsigned PC_INC           = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry pc/instruction buffer catching a fetch that lands while the output slot is blocked
module fetch_skid #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              unload_i,
   input  logic              clear_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [31:0]       inst_i,
   output logic              full_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [31:0]       inst_o
);

   logic              full_q, full_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       inst_q, inst_d;

   // Clear wins so a redirect never leaves a wrong-path entry behind
   always_comb begin
      full_d = full_q;
      pc_d   = pc_q;
      inst_d = inst_q;
      if (clear_i) begin
         full_d = 1'b0;
      end else if (load_i) begin
         full_d = 1'b1;
         pc_d   = pc_i;
         inst_d = inst_i;
      end else if (unload_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         pc_q   <= '0;
         inst_q <= '0;
      end else begin
         full_q <= full_d;
         pc_q   <= pc_d;
         inst_q <= inst_d;
      end
   end

   assign full_o = full_q;
   assign pc_o   = pc_q;
   assign inst_o = inst_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage fetch sequencer: PC, SRAM handshake, redirect squash, output slot.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              branch,
   input  logic [ADDR_W-1:0] branch_pc,
   input  logic              stall,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [31:0]       if_inst,
   output logic              kill,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_redirect_cnt
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic              slot_valid_q, slot_valid_d;
   logic [ADDR_W-1:0] slot_pc_q, slot_pc_d;
   logic [31:0]       slot_inst_q, slot_inst_d;
   logic              kill_q, kill_d;

   logic              skid_load, skid_unload, skid_clear, skid_full;
   logic [ADDR_W-1:0] skid_pc;
   logic [31:0]       skid_inst;
   logic              drain;

   assign drain = slot_valid_q & ~stall;

   fetch_skid #(
      .ADDR_W (ADDR_W)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .clear_i  (skid_clear),
      .pc_i     (pc_q),
      .inst_i   (imem_rdata),
      .full_o   (skid_full),
      .pc_o     (skid_pc),
      .inst_o   (skid_inst)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      target_d     = target_q;
      slot_valid_d = slot_valid_q;
      slot_pc_d    = slot_pc_q;
      slot_inst_d  = slot_inst_q;
      kill_d       = 1'b0;
      skid_load    = 1'b0;
      skid_unload  = 1'b0;
      skid_clear   = 1'b0;

      if (branch) begin
         slot_valid_d = 1'b0;
         skid_clear   = 1'b0 | 1'b1;
         kill_d       = slot_valid_q | skid_full;
         unique case (state_q)
            FETCH, DROP: begin
               // An ack this cycle retires the outstanding request, so the target can issue directly
               if (imem_ack) begin
                  pc_d    = branch_pc;
                  state_d = FETCH;
               end else begin
                  target_d = branch_pc;
                  state_d  = DROP;
               end
            end
            default: begin
               pc_d    = branch_pc;
               state_d = FETCH;
            end
         endcase
      end else begin
         if (drain) begin
            slot_valid_d = 1'b0;
         end
         unique case (state_q)
            BOOT: begin
               state_d = FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  pc_d = pc_q + ADDR_W'(PC_INC);
                  if (!slot_valid_q || drain) begin
                     slot_valid_d = 1'b1;
                     slot_pc_d    = pc_q;
                     slot_inst_d  = imem_rdata;
                  end else begin
                     skid_load = 1'b1;
                     state_d   = HOLD;
                  end
               end
            end
            HOLD: begin
               if (drain) begin
                  slot_valid_d = 1'b1;
                  slot_pc_d    = skid_pc;
                  slot_inst_d  = skid_inst;
                  skid_unload  = 1'b1;
                  state_d      = FETCH;
               end
            end
            DROP: begin
               if (imem_ack) begin
                  pc_d    = target_q;
                  state_d = FETCH;
               end
            end
            default: begin
               state_d = BOOT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         target_q     <= '0;
         slot_valid_q <= 1'b0;
         slot_pc_q    <= '0;
         slot_inst_q  <= '0;
         kill_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         target_q     <= target_d;
         slot_valid_q <= slot_valid_d;
         slot_pc_q    <= slot_pc_d;
         slot_inst_q  <= slot_inst_d;
         kill_q       <= kill_d;
      end
   end

   assign imem_req  = (state_q == FETCH) || (state_q == DROP);
   assign imem_addr = pc_q;
   assign if_valid  = slot_valid_q;
   assign if_pc     = slot_pc_q;
   assign if_inst   = slot_inst_q;
   assign kill      = kill_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] redir_cnt_q, redir_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if (slot_valid_q && stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (branch && (redir_cnt_q != 32'hFFFF_FFFF)) begin
         redir_cnt_d = redir_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign perf_stall_cnt    = stall_cnt_q;
   assign perf_redirect_cnt = redir_cnt_q;
`else
   assign perf_stall_cnt    = 32'h0;
   assign perf_redirect_cnt = 32'h0;
`endif

endmodule
